// File: rtl/fft_pkg.sv
// Shared definitions for the iterative radix-2 FFT sequencer: state encoding,
// butterfly window length and width helpers for the stage/twiddle buses.
package fft_pkg;

    // Butterfly unit latency/window in clock cycles (one strobe per window).
    localparam int BFLY_PERIOD = 5;

    // Width of the phase counter that walks through one butterfly window.
    localparam int PHASE_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Width of the stage index: ceil(log2(n_log2)), at least one bit.
    function automatic int stage_w(input int n_log2);
        return (n_log2 < 2) ? 1 : $clog2(n_log2);
    endfunction

    // Width of the twiddle ROM address (N/2 entries).
    function automatic int tw_w(input int n_log2);
        return n_log2 - 1;
    endfunction

endpackage

// File: rtl/fft_iter_seq_if.sv
// Control bus between the FFT sequencer and its data RAM / twiddle ROM /
// butterfly unit. The sequencer is the master; the datapath side is the slave.
interface fft_iter_seq_if
    import fft_pkg::*;
#(
    parameter int N_LOG2 = 4
) ();

    localparam int SW = stage_w(N_LOG2);
    localparam int TW = tw_w(N_LOG2);

    logic              start;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [N_LOG2-1:0] rd_addr_a;
    logic [N_LOG2-1:0] rd_addr_b;
    logic [TW-1:0]     tw_addr;
    logic              bfly_strb;
    logic              wr_en;
    logic [N_LOG2-1:0] wr_addr_a;
    logic [N_LOG2-1:0] wr_addr_b;
    logic [SW-1:0]     stage_idx;

    modport master (
        input  start,
        output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               bfly_strb, wr_en, wr_addr_a, wr_addr_b, stage_idx
    );

    modport slave (
        output start,
        input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               bfly_strb, wr_en, wr_addr_a, wr_addr_b, stage_idx
    );

endinterface

// File: rtl/fft_iter_addr_gen.sv
// Combinational DIT butterfly address generator: for stage s and butterfly j
// produces the operand pair addresses and the twiddle ROM index.
module fft_iter_addr_gen
    import fft_pkg::*;
#(
    parameter  int N_LOG2 = 4,
    localparam int SW     = stage_w(N_LOG2),
    localparam int TW     = tw_w(N_LOG2)
) (
    input  logic [SW-1:0]     s,
    input  logic [N_LOG2-1:0] j,
    output logic [N_LOG2-1:0] addr_a,
    output logic [N_LOG2-1:0] addr_b,
    output logic [TW-1:0]     tw_addr
);

    logic [N_LOG2-1:0] span;
    logic [N_LOG2-1:0] pos;
    logic [N_LOG2-1:0] grp;
    logic [TW-1:0]     pos_tw;
    logic [SW-1:0]     tw_shift;

    // span = 2^s; pos/grp split j into offset within group and group number.
    always_comb begin
        span     = {{(N_LOG2-1){1'b0}}, 1'b1} << s;
        pos      = j & (span - N_LOG2'(1));
        grp      = j >> s;
        addr_a   = ((grp << s) << 1) | pos;
        addr_b   = addr_a + span;
        tw_shift = SW'(N_LOG2 - 1) - s;
        pos_tw   = TW'(pos);
        tw_addr  = pos_tw << tw_shift;
    end

endmodule

// File: rtl/fft_iter_seq.sv
// Iterative in-place radix-2 DIT FFT sequencer. Issues one butterfly strobe
// every BFLY_PERIOD cycles, N/2 per stage plus one flush window, and writes
// each butterfly's result one cycle after the following strobe.
module fft_iter_seq #(
    parameter int N_LOG2      = 4,
    parameter int BFLY_PERIOD = fft_pkg::BFLY_PERIOD
) (
    input  logic           clk,
    input  logic           rst,
    fft_iter_seq_if.master bus
);

    import fft_pkg::*;

    localparam int SW   = stage_w(N_LOG2);
    localparam int TW   = tw_w(N_LOG2);
    localparam int HALF = 1 << (N_LOG2 - 1);

    localparam logic [PHASE_W-1:0] PH_LAST = PHASE_W'(BFLY_PERIOD - 1);
    localparam logic [PHASE_W-1:0] PH_WR   = PHASE_W'(1);
    localparam logic [N_LOG2-1:0]  J_LAST  = N_LOG2'(HALF - 1);
    localparam logic [N_LOG2-1:0]  J_FLUSH = N_LOG2'(HALF);
    localparam logic [SW-1:0]      S_LAST  = SW'(N_LOG2 - 1);

    // Sequencing counters: they describe the current cycle.
    state_e              state_q, state_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [SW-1:0]       stage_q, stage_d;
    logic [N_LOG2-1:0]   bfly_q,  bfly_d;

    // Registered outputs plus the held addresses of the previous butterfly.
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;
    logic                rd_en_q,     rd_en_d;
    logic                strb_q,      strb_d;
    logic                wr_en_q,     wr_en_d;
    logic [N_LOG2-1:0]   rd_addr_a_q, rd_addr_a_d;
    logic [N_LOG2-1:0]   rd_addr_b_q, rd_addr_b_d;
    logic [TW-1:0]       tw_addr_q,   tw_addr_d;
    logic [N_LOG2-1:0]   hold_a_q,    hold_a_d;
    logic [N_LOG2-1:0]   hold_b_q,    hold_b_d;
    logic [N_LOG2-1:0]   wr_addr_a_q, wr_addr_a_d;
    logic [N_LOG2-1:0]   wr_addr_b_q, wr_addr_b_d;

    logic [N_LOG2-1:0]   gen_addr_a;
    logic [N_LOG2-1:0]   gen_addr_b;
    logic [TW-1:0]       gen_tw;

    // Addresses for the butterfly that the next cycle will strobe.
    fft_iter_addr_gen #(
        .N_LOG2 (N_LOG2)
    ) u_addr_gen (
        .s       (stage_d),
        .j       (bfly_d),
        .addr_a  (gen_addr_a),
        .addr_b  (gen_addr_b),
        .tw_addr (gen_tw)
    );

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            stage_q     <= '0;
            bfly_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            strb_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            tw_addr_q   <= '0;
            hold_a_q    <= '0;
            hold_b_q    <= '0;
            wr_addr_a_q <= '0;
            wr_addr_b_q <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            stage_q     <= stage_d;
            bfly_q      <= bfly_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            strb_q      <= strb_d;
            wr_en_q     <= wr_en_d;
            rd_addr_a_q <= rd_addr_a_d;
            rd_addr_b_q <= rd_addr_b_d;
            tw_addr_q   <= tw_addr_d;
            hold_a_q    <= hold_a_d;
            hold_b_q    <= hold_b_d;
            wr_addr_a_q <= wr_addr_a_d;
            wr_addr_b_q <= wr_addr_b_d;
        end
    end

    // Next-state: walk phase 0..4, butterflies 0..N/2-1, flush window, stages.
    always_comb begin
        // NOTE: hold-value defaults before the case so no path infers a latch.
        state_d = state_q;
        phase_d = phase_q;
        stage_d = stage_q;
        bfly_d  = bfly_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    phase_d = '0;
                    stage_d = '0;
                    bfly_d  = '0;
                end
            end
            ST_RUN: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    if (bfly_q == J_LAST) begin
                        bfly_d  = J_FLUSH;
                        state_d = ST_FLUSH;
                    end else begin
                        bfly_d = bfly_q + N_LOG2'(1);
                    end
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            ST_FLUSH: begin
                if (stage_q == S_LAST && phase_q == PH_WR) begin
                    // Last stage: stop right after the final write.
                    state_d = ST_DONE;
                    phase_d = '0;
                    stage_d = '0;
                    bfly_d  = '0;
                end else if (phase_q == PH_LAST) begin
                    state_d = ST_RUN;
                    phase_d = '0;
                    stage_d = stage_q + SW'(1);
                    bfly_d  = '0;
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next-cycle counters, so outputs are registered.
    always_comb begin
        busy_d  = (state_d == ST_RUN) || (state_d == ST_FLUSH);
        done_d  = (state_d == ST_DONE);
        strb_d  = busy_d && (phase_d == '0);
        rd_en_d = (state_d == ST_RUN) && (phase_d == '0);
        // A stage's first butterfly has no predecessor result to write.
        wr_en_d = busy_d && (phase_d == PH_WR) && (bfly_d != '0);

        rd_addr_a_d = rd_en_d ? gen_addr_a : rd_addr_a_q;
        rd_addr_b_d = rd_en_d ? gen_addr_b : rd_addr_b_q;
        tw_addr_d   = rd_en_d ? gen_tw     : tw_addr_q;

        // On every strobe, remember the butterfly read at the previous strobe.
        hold_a_d = strb_d ? rd_addr_a_q : hold_a_q;
        hold_b_d = strb_d ? rd_addr_b_q : hold_b_q;

        wr_addr_a_d = wr_en_d ? hold_a_q : wr_addr_a_q;
        wr_addr_b_d = wr_en_d ? hold_b_q : wr_addr_b_q;
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.bfly_strb = strb_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.rd_addr_a = rd_addr_a_q;
    assign bus.rd_addr_b = rd_addr_b_q;
    assign bus.tw_addr   = tw_addr_q;
    assign bus.wr_addr_a = wr_addr_a_q;
    assign bus.wr_addr_b = wr_addr_b_q;
    assign bus.stage_idx = stage_q;

endmodule
